// File: rtl/s2mm_dma.sv
// Stream-to-memory writer: each AXI-Stream beat becomes one full-width AXI-Lite write at an
// incrementing address, with a beat limit, start/busy/done control, response checking and irq.
module s2mm_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ps_wvalid,
  input  logic [3:0]              ps_waddr,
  input  logic [31:0]             ps_wdata,
  output logic                    ps_wready,
  output logic                    ps_wresp,
  input  logic                    ps_arvalid,
  input  logic [3:0]              ps_raddr,
  output logic [31:0]             ps_rdata,
  output logic                    ps_rvalid,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic                    irq
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BPB);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_RESP, S_FIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] dst_q, addr_q, addr_d, dst_d;
  logic [CNT_WIDTH-1:0]  max_q, beats_q, beats_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  last_q, irq_en_q, busy_q, done_q, slverr_q, ovf_q;
  logic                  tready_q, awvalid_q, wvalid_q, bready_q, wresp_q;
  logic                  wr_dst, wr_max, wr_ctrl, wr_stat, aw_pend, w_pend;

  assign wr_dst  = ps_wvalid && (ps_waddr == 4'd0) && !busy_q;
  assign wr_max  = ps_wvalid && (ps_waddr == 4'd1) && !busy_q;
  assign wr_ctrl = ps_wvalid && (ps_waddr == 4'd2);
  assign wr_stat = ps_wvalid && (ps_waddr == 4'd3);

  assign dst_d   = ps_wdata[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(BPB - 1);
  assign addr_d  = addr_q + ADDR_WIDTH'(BPB);
  assign beats_d = beats_q + 1'b1;
  assign aw_pend = awvalid_q && !m_awready;
  assign w_pend  = wvalid_q && !m_wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dst_q     <= '0;
      addr_q    <= '0;
      max_q     <= '0;
      beats_q   <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      slverr_q  <= 1'b0;
      ovf_q     <= 1'b0;
      tready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wresp_q   <= 1'b0;
    end else begin
      wresp_q <= ps_wvalid;
      if (wr_dst)  dst_q    <= dst_d;
      if (wr_max)  max_q    <= ps_wdata[CNT_WIDTH-1:0];
      if (wr_ctrl) irq_en_q <= ps_wdata[1];
      // W1C first so that any hardware set later in this block takes priority
      if (wr_stat) begin
        if (ps_wdata[1]) done_q   <= 1'b0;
        if (ps_wdata[2]) slverr_q <= 1'b0;
        if (ps_wdata[3]) ovf_q    <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (wr_ctrl && ps_wdata[0]) begin
            if (max_q != '0) begin
              beats_q  <= '0;
              done_q   <= 1'b0;
              slverr_q <= 1'b0;
              ovf_q    <= 1'b0;
              addr_q   <= dst_q;
              busy_q   <= 1'b1;
              tready_q <= 1'b1;
              state_q  <= S_WAIT;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (s_tvalid) begin
            wdata_q   <= s_tdata;
            last_q    <= s_tlast;
            tready_q  <= 1'b0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready)  wvalid_q  <= 1'b0;
          if (!aw_pend && !w_pend) begin
            bready_q <= 1'b1;
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          if (m_bvalid) begin
            beats_q  <= beats_d;
            addr_q   <= addr_d;
            bready_q <= 1'b0;
            if (m_bresp != 2'b00) begin
              slverr_q <= 1'b1;
              state_q  <= S_FIN;
            end else if (last_q) begin
              state_q <= S_FIN;
            end else if (beats_d == max_q) begin
              ovf_q   <= 1'b1;
              state_q <= S_FIN;
            end else begin
              tready_q <= 1'b1;
              state_q  <= S_WAIT;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ps_rdata = '0;
    case (ps_raddr)
      4'd0:    ps_rdata = 32'(dst_q);
      4'd1:    ps_rdata = 32'(max_q);
      4'd2:    ps_rdata = {30'd0, irq_en_q, 1'b0};
      4'd3:    ps_rdata = {28'd0, ovf_q, slverr_q, done_q, busy_q};
      4'd4:    ps_rdata = 32'(beats_q);
      4'd5:    ps_rdata = 32'(beats_q) << OFF;
      default: ps_rdata = '0;
    endcase
  end

  assign ps_wready = 1'b1;
  assign ps_wresp  = wresp_q;
  assign ps_rvalid = ps_arvalid;
  assign s_tready  = tready_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = '1;
  assign m_bready  = bready_q;
  assign irq       = irq_en_q & done_q;

endmodule
